otter_cu_seq: RTL and testbench

Parametrised multi-cycle control sequencer for the OTTER core. It supersedes the fixed-timing control FSM and sits between the instruction register/decoder and the datapath enables. It adds:
- variable-latency instruction and data memory handshakes with a bus-timeout trap;
- an explicit fetch state;
- `NUM_IRQ` edge-triggered interrupt lines with pending latches and fixed-priority selection.

---
 rtl/otter_cu_seq_pkg.sv | 51 +++++
 rtl/otter_irq_pend.sv | 54 +++++
 rtl/otter_cu_seq.sv | 179 +++++++++++++++++
 tb/tb_otter_cu_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/otter_cu_seq_pkg.sv
// rtl/otter_cu_seq_pkg.sv - shared defines for the OTTER control sequencer
//
// Purpose: state encodings, RV32I opcode and funct3 constants, and
// instruction field extractors used by otter_cu_seq.
// Ports: none (package).
package otter_cu_seq_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WR_BK  = 3'd4,
    ST_INTRPT = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // SYSTEM funct3 values: 000 is ECALL/EBREAK/MRET (no CSR write), 100 is unused.
  localparam logic [2:0] F3_PRIV   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  function automatic logic [6:0] instrn_opcode(input logic [31:0] ins);
    return ins[6:0];
  endfunction

  function automatic logic [2:0] instrn_funct3(input logic [31:0] ins);
    return ins[14:12];
  endfunction

  function automatic logic is_csr_funct3(input logic [2:0] f3);
    return (f3 == F3_CSRRW)  || (f3 == F3_CSRRS)  || (f3 == F3_CSRRC) ||
           (f3 == F3_CSRRWI) || (f3 == F3_CSRRSI) || (f3 == F3_CSRRCI);
  endfunction

endpackage

// File: rtl/otter_irq_pend.sv
// rtl/otter_irq_pend.sv - interrupt edge detect, pending latches and priority select
//
// Purpose: latches rising edges of each request line into a pending bit,
// reports the lowest-index pending bit, and clears one bit by index.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   intrpt_req    - request levels, a 0->1 edge raises a request
//   clr_vld       - clear the pending bit selected by clr_id this edge
//   clr_id        - index of the bit to clear
//   pending_any   - at least one pending bit is set
//   pend_id       - lowest-index pending bit (0 when none)
module otter_irq_pend #(
  parameter int NUM_IRQ = 4,
  parameter int IRQ_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] intrpt_req,
  input  logic               clr_vld,
  input  logic [IRQ_W-1:0]   clr_id,
  output logic               pending_any,
  output logic [IRQ_W-1:0]   pend_id
);

  logic [NUM_IRQ-1:0] req_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr_mask;

  assign rise     = intrpt_req & ~req_q;
  assign clr_mask = clr_vld ? (NUM_IRQ'(1) << clr_id) : '0;

  // A new edge on the bit being cleared keeps it pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      pending <= '0;
    end else begin
      req_q   <= intrpt_req;
      pending <= (pending & ~clr_mask) | rise;
    end
  end

  assign pending_any = |pending;

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    pend_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) pend_id = IRQ_W'(i);
    end
  end

endmodule

// File: rtl/otter_cu_seq.sv
// rtl/otter_cu_seq.sv - multi-cycle OTTER control sequencer with memory waits and interrupts
//
// Purpose: drives datapath enables for each instruction phase, waits on
// variable-latency memory acks with a bus timeout, and enters interrupts
// between instructions.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   instrn                   - current instruction (stable EXEC..next FETCH)
//   imem_ack, dmem_ack       - memory handshake completions
//   intrpt_req, intrpt_en    - interrupt request lines, global enable
//   pc_w_en, rfile_w_en      - PC and register file writes
//   imem_r_en                - instruction fetch request
//   dmem_r_en, dmem_w_en     - data read/write requests
//   csr_we                   - CSR write
//   intrpt_taken, intrpt_id  - interrupt entry cycle and its index
//   bus_err                  - bus timeout, held until reset
module otter_cu_seq
  import otter_cu_seq_pkg::*;
#(
  parameter int NUM_IRQ  = 4,
  parameter int MAX_WAIT = 16,
  parameter int IRQ_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instrn,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  input  logic [NUM_IRQ-1:0] intrpt_req,
  input  logic               intrpt_en,
  output logic               pc_w_en,
  output logic               rfile_w_en,
  output logic               imem_r_en,
  output logic               dmem_r_en,
  output logic               dmem_w_en,
  output logic               csr_we,
  output logic               intrpt_taken,
  output logic [IRQ_W-1:0]   intrpt_id,
  output logic               bus_err
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             cnt_inc;
  logic             wait_last;
  logic             pending_any;
  logic [IRQ_W-1:0] pend_id;
  logic             clr_vld;
  logic [6:0]       opc;
  logic [2:0]       f3;
  logic             is_load, is_store;
  state_t           done_state;
  logic             instrn_unused;

  assign opc           = instrn_opcode(instrn);
  assign f3            = instrn_funct3(instrn);
  assign is_load       = (opc == OPC_LOAD);
  assign is_store      = (opc == OPC_STORE);
  assign instrn_unused = ^{instrn[31:15], instrn[11:7]};

  assign wait_last  = (MAX_WAIT != 0) && (wait_cnt == WAIT_LAST);
  assign done_state = (intrpt_en && pending_any) ? ST_INTRPT : ST_FETCH;

  otter_irq_pend #(
    .NUM_IRQ (NUM_IRQ),
    .IRQ_W   (IRQ_W)
  ) u_irq_pend (
    .clk         (clk),
    .rst         (rst),
    .intrpt_req  (intrpt_req),
    .clr_vld     (clr_vld),
    .clr_id      (pend_id),
    .pending_any (pending_any),
    .pend_id     (pend_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) wait_cnt <= '0;
      else if (cnt_inc)       wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_w_en      = 1'b0;
    rfile_w_en   = 1'b0;
    imem_r_en    = 1'b0;
    dmem_r_en    = 1'b0;
    dmem_w_en    = 1'b0;
    csr_we       = 1'b0;
    intrpt_taken = 1'b0;
    intrpt_id    = '0;
    bus_err      = 1'b0;
    clr_vld      = 1'b0;
    cnt_inc      = 1'b0;

    case (state)
      ST_INIT: state_nxt = ST_FETCH;

      ST_FETCH: begin
        imem_r_en = 1'b1;
        if (imem_ack) begin
          state_nxt = ST_EXEC;
        end else begin
          cnt_inc = 1'b1;
          if (wait_last) state_nxt = ST_TRAP;
        end
      end

      ST_EXEC: begin
        if (is_load) begin
          dmem_r_en = 1'b1;
          state_nxt = ST_MEM;
        end else if (is_store) begin
          dmem_w_en = 1'b1;
          state_nxt = ST_MEM;
        end else begin
          pc_w_en = 1'b1;
          case (opc)
            OPC_OP, OPC_OP_IMM, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC:
              rfile_w_en = 1'b1;
            OPC_SYSTEM: begin
              if (is_csr_funct3(f3)) begin
                csr_we     = 1'b1;
                rfile_w_en = 1'b1;
              end
            end
            default: ;
          endcase
          state_nxt = done_state;
        end
      end

      // instrn is still the load/store that entered MEM.
      ST_MEM: begin
        dmem_r_en = is_load;
        dmem_w_en = is_store;
        if (dmem_ack) begin
          if (is_load) begin
            state_nxt = ST_WR_BK;
          end else begin
            pc_w_en   = 1'b1;
            state_nxt = done_state;
          end
        end else begin
          cnt_inc = 1'b1;
          if (wait_last) state_nxt = ST_TRAP;
        end
      end

      ST_WR_BK: begin
        rfile_w_en = 1'b1;
        pc_w_en    = 1'b1;
        state_nxt  = done_state;
      end

      ST_INTRPT: begin
        intrpt_taken = 1'b1;
        pc_w_en      = 1'b1;
        intrpt_id    = pend_id;
        clr_vld      = 1'b1;
        state_nxt    = ST_FETCH;
      end

      ST_TRAP: bus_err = 1'b1;

      default: state_nxt = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_otter_cu_seq.sv
// tb/tb_otter_cu_seq.sv - self-checking bench for otter_cu_seq
module tb_otter_cu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrn;
  logic        imem_ack, dmem_ack;
  logic [3:0]  intrpt_req;
  logic        intrpt_en;
  logic        pc_w_en, rfile_w_en, imem_r_en, dmem_r_en, dmem_w_en, csr_we;
  logic        intrpt_taken, bus_err;
  logic [1:0]  intrpt_id;

  int checks = 0;
  int errors = 0;

  otter_cu_seq #(.NUM_IRQ(4), .MAX_WAIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .instrn       (instrn),
    .imem_ack     (imem_ack),
    .dmem_ack     (dmem_ack),
    .intrpt_req   (intrpt_req),
    .intrpt_en    (intrpt_en),
    .pc_w_en      (pc_w_en),
    .rfile_w_en   (rfile_w_en),
    .imem_r_en    (imem_r_en),
    .dmem_r_en    (dmem_r_en),
    .dmem_w_en    (dmem_w_en),
    .csr_we       (csr_we),
    .intrpt_taken (intrpt_taken),
    .intrpt_id    (intrpt_id),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  // Output vector: {pc, rf, imem_r, dmem_r, dmem_w, csr, taken, id[1:0], bus_err}
  localparam logic [9:0] Z   = 10'b0;
  localparam logic [9:0] PC  = 10'b1000000000;
  localparam logic [9:0] RF  = 10'b0100000000;
  localparam logic [9:0] IR  = 10'b0010000000;
  localparam logic [9:0] DR  = 10'b0001000000;
  localparam logic [9:0] DW  = 10'b0000100000;
  localparam logic [9:0] CS  = 10'b0000010000;
  localparam logic [9:0] TK  = 10'b0000001000;
  localparam logic [9:0] BE  = 10'b0000000001;
  function automatic logic [9:0] id(input int n);
    return 10'(n << 1);
  endfunction

  localparam logic [31:0] ADDI  = 32'h00100093;
  localparam logic [31:0] LW    = 32'h00002103;
  localparam logic [31:0] SW    = 32'h00202023;
  localparam logic [31:0] BEQ   = 32'h00000063;
  localparam logic [31:0] CSRRW = 32'h300110F3;
  localparam logic [31:0] ECALL = 32'h00000073;
  localparam logic [31:0] BAD   = 32'h00000000;
  localparam logic [31:0] LUI   = 32'h000010B7;

  typedef struct {
    string       name;
    logic        r;
    logic [31:0] ins;
    logic        ia;
    logic        da;
    logic [3:0]  irq;
    logic        en;
    logic [9:0]  exp;
  } vec_t;

  vec_t        tbl[$];
  logic [9:0]  sb_q[$];

  function automatic void add(input string n, input logic r, input logic [31:0] ins,
                              input logic ia, input logic da, input logic [3:0] irq,
                              input logic en, input logic [9:0] exp);
    vec_t v;
    v.name = n; v.r = r; v.ins = ins; v.ia = ia; v.da = da;
    v.irq = irq; v.en = en; v.exp = exp;
    tbl.push_back(v);
  endfunction

  // One clock: drive inputs after the edge, record expectation, compare at negedge.
  task automatic step(input string n, input logic r, input logic [31:0] ins,
                      input logic ia, input logic da, input logic [3:0] irq,
                      input logic en, input logic [9:0] exp);
    logic [9:0] got, want;
    @(posedge clk); #1;
    rst = r; instrn = ins; imem_ack = ia; dmem_ack = da;
    intrpt_req = irq; intrpt_en = en;
    sb_q.push_back(exp);
    @(negedge clk);
    got = {pc_w_en, rfile_w_en, imem_r_en, dmem_r_en, dmem_w_en, csr_we,
           intrpt_taken, intrpt_id, bus_err};
    want = sb_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b required %b (pc rf ir dr dw csr tk id be)", n, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; instrn = '0; imem_ack = 1'b0; dmem_ack = 1'b0;
    intrpt_req = '0; intrpt_en = 1'b0;
    repeat (2) @(posedge clk);

    // Straight-line instruction mix with interrupts disabled.
    add("reset_state",   1, ADDI,  0, 0, 4'b0000, 0, Z);
    add("init",          0, ADDI,  0, 0, 4'b0000, 0, Z);
    add("addi_fetch",    0, ADDI,  1, 0, 4'b0000, 0, IR);
    add("addi_exec",     0, ADDI,  0, 0, 4'b0000, 0, PC | RF);
    add("lw_fetch",      0, LW,    1, 0, 4'b0000, 0, IR);
    add("lw_exec",       0, LW,    0, 0, 4'b0000, 0, DR);
    add("lw_mem_wait1",  0, LW,    0, 0, 4'b0000, 0, DR);
    add("lw_mem_wait2",  0, LW,    0, 0, 4'b0000, 0, DR);
    add("lw_mem_ack",    0, LW,    0, 1, 4'b0000, 0, DR);
    add("lw_wr_bk",      0, LW,    0, 0, 4'b0000, 0, PC | RF);
    add("sw_fetch",      0, SW,    1, 0, 4'b0000, 0, IR);
    add("sw_exec",       0, SW,    0, 0, 4'b0000, 0, DW);
    add("sw_mem_ack",    0, SW,    0, 1, 4'b0000, 0, DW | PC);
    add("beq_fetch",     0, BEQ,   1, 0, 4'b0000, 0, IR);
    add("beq_exec",      0, BEQ,   0, 0, 4'b0000, 0, PC);
    add("csrrw_fetch",   0, CSRRW, 1, 0, 4'b0000, 0, IR);
    add("csrrw_exec",    0, CSRRW, 0, 0, 4'b0000, 0, PC | RF | CS);
    add("ecall_fetch",   0, ECALL, 1, 0, 4'b0000, 0, IR);
    add("ecall_exec",    0, ECALL, 0, 0, 4'b0000, 0, PC);
    add("bad_fetch",     0, BAD,   1, 1, 4'b0000, 0, IR);
    add("bad_exec_acks", 0, BAD,   1, 1, 4'b0000, 0, PC);
    add("lui_fetch",     0, LUI,   1, 0, 4'b0000, 0, IR);
    add("lui_exec",      0, LUI,   0, 0, 4'b0000, 0, PC | RF);

    foreach (tbl[i])
      step(tbl[i].name, tbl[i].r, tbl[i].ins, tbl[i].ia, tbl[i].da,
           tbl[i].irq, tbl[i].en, tbl[i].exp);

    // Simultaneous edges on [3] and [1] during a load; lowest index first.
    step("irq_lw_fetch",   0, LW,   1, 0, 4'b0000, 1, IR);
    step("irq_lw_exec",    0, LW,   0, 0, 4'b1010, 1, DR);
    step("irq_lw_mem",     0, LW,   0, 1, 4'b1010, 1, DR);
    step("irq_lw_wr_bk",   0, LW,   0, 0, 4'b1000, 1, PC | RF);
    step("irq_take_1",     0, ADDI, 0, 0, 4'b1010, 1, PC | TK | id(1));
    step("irq_fetch_a",    0, ADDI, 1, 0, 4'b1010, 1, IR);
    step("irq_exec_a",     0, ADDI, 0, 0, 4'b1010, 1, PC | RF);
    step("irq_retake_1",   0, ADDI, 0, 0, 4'b1010, 1, PC | TK | id(1));
    step("irq_fetch_b",    0, ADDI, 1, 0, 4'b1010, 1, IR);
    step("irq_exec_b",     0, ADDI, 0, 0, 4'b1010, 1, PC | RF);
    step("irq_take_3",     0, ADDI, 0, 0, 4'b1001, 1, PC | TK | id(3));
    // Pending [0] held across a disabled window.
    step("irq_dis_fetch",  0, ADDI, 1, 0, 4'b1001, 0, IR);
    step("irq_dis_exec",   0, ADDI, 0, 0, 4'b1001, 0, PC | RF);
    step("irq_en_fetch",   0, ADDI, 1, 0, 4'b1001, 0, IR);
    step("irq_en_exec",    0, ADDI, 0, 0, 4'b1001, 1, PC | RF);
    step("irq_take_0",     0, ADDI, 0, 0, 4'b1001, 1, PC | TK | id(0));

    // Ack on the 4th wait cycle avoids the trap.
    step("wait_f1",        0, ADDI, 0, 0, 4'b1001, 1, IR);
    step("wait_f2",        0, ADDI, 0, 0, 4'b1001, 1, IR);
    step("wait_f3",        0, ADDI, 0, 0, 4'b1001, 1, IR);
    step("wait_f4_ack",    0, ADDI, 1, 0, 4'b1001, 1, IR);
    step("wait_exec",      0, ADDI, 0, 0, 4'b1001, 1, PC | RF);
    // Stuck ack: trap after four FETCH cycles, absorbing.
    step("trap_f1",        0, ADDI, 0, 0, 4'b1001, 1, IR);
    step("trap_f2",        0, ADDI, 0, 0, 4'b1001, 1, IR);
    step("trap_f3",        0, ADDI, 0, 0, 4'b1001, 1, IR);
    step("trap_f4",        0, ADDI, 0, 0, 4'b1001, 1, IR);
    step("trap_entry",     0, ADDI, 0, 0, 4'b1001, 1, BE);
    step("trap_hold_acks", 0, LW,   1, 1, 4'b1001, 1, BE);
    step("trap_rst_cycle", 1, ADDI, 0, 0, 4'b0000, 1, BE);
    step("trap_to_init",   0, ADDI, 0, 0, 4'b0000, 1, Z);

    // Reset during the 2nd MEM wait of a store with an interrupt pending.
    step("rst_sw_fetch",   0, SW,   1, 0, 4'b0100, 1, IR);
    step("rst_sw_exec",    0, SW,   0, 0, 4'b0100, 1, DW);
    step("rst_sw_wait1",   0, SW,   0, 0, 4'b0100, 1, DW);
    step("rst_sw_wait2",   1, SW,   0, 0, 4'b0000, 1, DW);
    step("rst_init",       0, ADDI, 0, 0, 4'b0000, 1, Z);
    step("rst_fetch",      0, ADDI, 1, 0, 4'b0000, 1, IR);
    // Pending was cleared, and an edge in the final cycle waits one instruction.
    step("rst_exec_late",  0, ADDI, 0, 0, 4'b0010, 1, PC | RF);
    step("late_fetch",     0, ADDI, 1, 0, 4'b0010, 1, IR);
    step("late_exec",      0, ADDI, 0, 0, 4'b0010, 1, PC | RF);
    step("late_take_1",    0, ADDI, 0, 0, 4'b0010, 1, PC | TK | id(1));
    step("late_fetch2",    0, ADDI, 0, 0, 4'b0010, 1, IR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
